// File: rtl/icache_pkg.sv
// Shared types and address helpers for the direct-mapped instruction cache.
//   icache_state_e : refill FSM states
//   addr_field     : extract a bit field from a byte address
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MISS_REQ = 2'd1,
      REFILL   = 2'd2,
      RESPOND  = 2'd3
   } icache_state_e;

   // Returns addr[lsb +: bits], zero-extended to 64 bits.
   function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                              input int unsigned lsb,
                                              input int unsigned bits);
      logic [63:0] mask;
      mask = (bits >= 64) ? '1 : ((64'd1 << bits) - 64'd1);
      return (addr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays of the instruction cache.
//   lookup_*   : combinational read of valid, tag and one word of a set
//   wr_*       : refill word write (synchronous)
//   commit_*   : mark a set valid and write its tag
//   flush_all  : invalidate every set (wins over commit)
module icache_line_store #(
   parameter int unsigned WORD_BITS = 32,
   parameter int unsigned SET_B     = 4,
   parameter int unsigned WIDX_B    = 2,
   parameter int unsigned TAG_B     = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [SET_B-1:0]     lookup_set,
   input  logic [WIDX_B-1:0]    lookup_widx,
   output logic                 lookup_valid_c,
   output logic [TAG_B-1:0]     lookup_tag_c,
   output logic [WORD_BITS-1:0] lookup_word_c,
   input  logic                 wr_en,
   input  logic [SET_B-1:0]     wr_set,
   input  logic [WIDX_B-1:0]    wr_widx,
   input  logic [WORD_BITS-1:0] wr_data,
   input  logic                 commit_en,
   input  logic [SET_B-1:0]     commit_set,
   input  logic [TAG_B-1:0]     commit_tag,
   input  logic                 flush_all
);
   localparam int unsigned LINES = 2 ** SET_B;
   localparam int unsigned WPL   = 2 ** WIDX_B;

   logic [LINES-1:0]     valid_q;
   logic [TAG_B-1:0]     tag_q  [LINES];
   logic [WORD_BITS-1:0] data_q [LINES][WPL];

   assign lookup_valid_c = valid_q[lookup_set];
   assign lookup_tag_c   = tag_q[lookup_set];
   assign lookup_word_c  = data_q[lookup_set][lookup_widx];

   // Valid bits are the only reset state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (flush_all) begin
         valid_q <= '0;
      end else if (commit_en) begin
         valid_q[commit_set] <= 1'b1;
      end
   end

   // Tag and data storage need no reset; they are qualified by valid.
   always_ff @(posedge clk) begin
      if (commit_en) tag_q[commit_set] <= commit_tag;
      if (wr_en)     data_q[wr_set][wr_widx] <= wr_data;
   end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache with blocking line refill.
//   req_*      : fetch request (valid/ready), byte address
//   resp_*     : one-cycle response pulse with the instruction word
//   flush      : invalidate all lines (deferred to IDLE if a miss is in flight)
//   mem_req_*  : line-aligned refill request to backing memory
//   mem_r*     : refill beats, in word order
module icache_direct_mapped
   import icache_pkg::*;
#(
   parameter int unsigned WORD_BITS      = 32,
   parameter int unsigned WORDS_PER_LINE = 4,
   parameter int unsigned LINE_COUNT     = 16,
   parameter int unsigned ADDR_BITS      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [ADDR_BITS-1:0] req_addr,
   output logic                 resp_valid,
   output logic [WORD_BITS-1:0] resp_data,
   input  logic                 flush,
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [ADDR_BITS-1:0] mem_req_addr,
   input  logic                 mem_rvalid,
   input  logic [WORD_BITS-1:0] mem_rdata
);
   localparam int unsigned OFS_B    = $clog2(WORD_BITS / 8);
   localparam int unsigned WIDX_B   = $clog2(WORDS_PER_LINE);
   localparam int unsigned SET_B    = $clog2(LINE_COUNT);
   localparam int unsigned TAG_B    = ADDR_BITS - SET_B - WIDX_B - OFS_B;
   localparam int unsigned LINE_LSB = OFS_B + WIDX_B;
   localparam int unsigned TAG_LSB  = LINE_LSB + SET_B;
   localparam logic [WIDX_B-1:0]    LAST_BEAT = WIDX_B'(WORDS_PER_LINE - 1);
   localparam logic [ADDR_BITS-1:0] LINE_MASK =
      ~((ADDR_BITS'(1) << LINE_LSB) - ADDR_BITS'(1));

   icache_state_e        state_q, state_n;
   logic                 flush_pend_q, flush_pend_n;
   logic [WIDX_B-1:0]    cnt_q, cnt_n;
   logic [WIDX_B-1:0]    widx_q, widx_n;
   logic [WORD_BITS-1:0] fwd_q, fwd_n;
   logic                 req_ready_n, resp_valid_n, mem_req_valid_n;
   logic [WORD_BITS-1:0] resp_data_n;
   logic [ADDR_BITS-1:0] mem_req_addr_n;

   logic [TAG_B-1:0]     req_tag, miss_tag, look_tag;
   logic [SET_B-1:0]     req_set, miss_set;
   logic [WIDX_B-1:0]    req_widx;
   logic                 look_valid;
   logic [WORD_BITS-1:0] look_word;
   logic                 wr_en, commit_en, flush_all;

   // Request fields for lookup; refill fields come from the latched line address.
   assign req_tag  = TAG_B'(addr_field(64'(req_addr), TAG_LSB, TAG_B));
   assign req_set  = SET_B'(addr_field(64'(req_addr), LINE_LSB, SET_B));
   assign req_widx = WIDX_B'(addr_field(64'(req_addr), OFS_B, WIDX_B));
   assign miss_tag = TAG_B'(addr_field(64'(mem_req_addr), TAG_LSB, TAG_B));
   assign miss_set = SET_B'(addr_field(64'(mem_req_addr), LINE_LSB, SET_B));

   icache_line_store #(
      .WORD_BITS (WORD_BITS),
      .SET_B     (SET_B),
      .WIDX_B    (WIDX_B),
      .TAG_B     (TAG_B)
   ) u_store (
      .clk            (clk),
      .rst_n          (rst_n),
      .lookup_set     (req_set),
      .lookup_widx    (req_widx),
      .lookup_valid_c (look_valid),
      .lookup_tag_c   (look_tag),
      .lookup_word_c  (look_word),
      .wr_en          (wr_en),
      .wr_set         (miss_set),
      .wr_widx        (cnt_q),
      .wr_data        (mem_rdata),
      .commit_en      (commit_en),
      .commit_set     (miss_set),
      .commit_tag     (miss_tag),
      .flush_all      (flush_all)
   );

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         flush_pend_q  <= 1'b0;
         cnt_q         <= '0;
         widx_q        <= '0;
         fwd_q         <= '0;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
      end else begin
         state_q       <= state_n;
         flush_pend_q  <= flush_pend_n;
         cnt_q         <= cnt_n;
         widx_q        <= widx_n;
         fwd_q         <= fwd_n;
         req_ready     <= req_ready_n;
         resp_valid    <= resp_valid_n;
         resp_data     <= resp_data_n;
         mem_req_valid <= mem_req_valid_n;
         mem_req_addr  <= mem_req_addr_n;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_n        = state_q;
      flush_pend_n   = flush_pend_q;
      cnt_n          = cnt_q;
      widx_n         = widx_q;
      fwd_n          = fwd_q;
      resp_valid_n   = 1'b0;
      resp_data_n    = resp_data;
      mem_req_addr_n = mem_req_addr;
      wr_en          = 1'b0;
      commit_en      = 1'b0;
      flush_all      = 1'b0;

      unique case (state_q)
         IDLE: begin
            flush_all    = flush | flush_pend_q;
            flush_pend_n = 1'b0;
            if (req_valid && req_ready) begin
               // A same-cycle flush forces a miss.
               if (look_valid && (look_tag == req_tag) && !flush) begin
                  resp_valid_n = 1'b1;
                  resp_data_n  = look_word;
               end else begin
                  mem_req_addr_n = req_addr & LINE_MASK;
                  widx_n         = req_widx;
                  state_n        = MISS_REQ;
               end
            end
         end
         MISS_REQ: begin
            if (flush) flush_pend_n = 1'b1;
            if (mem_req_valid && mem_req_ready) state_n = REFILL;
         end
         REFILL: begin
            if (flush) flush_pend_n = 1'b1;
            if (mem_rvalid) begin
               wr_en = 1'b1;
               cnt_n = cnt_q + WIDX_B'(1);
               if (cnt_q == widx_q) fwd_n = mem_rdata;
               if (cnt_q == LAST_BEAT) begin
                  commit_en    = 1'b1;
                  cnt_n        = '0;
                  state_n      = RESPOND;
                  resp_valid_n = 1'b1;
                  // Requested word may be this very beat.
                  resp_data_n  = (cnt_q == widx_q) ? mem_rdata : fwd_q;
               end
            end
         end
         RESPOND: begin
            if (flush) flush_pend_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      mem_req_valid_n = (state_n == MISS_REQ);
      // The IDLE cycle that applies a deferred flush accepts nothing.
      req_ready_n     = (state_n == IDLE) && !flush_pend_n;
   end

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped: directed steps with a
// response scoreboard and a simple backing-memory driver.
module tb_icache_direct_mapped;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int          checks = 0;
   int          passed = 0;
   int          resp_cnt = 0;
   logic [31:0] exp_q[$];

   icache_direct_mapped dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .flush         (flush),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   // Backing memory contents: line 0x10 holds 0xA0..0xA3.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[11:4] == 8'h01) return 32'hA0 + {30'b0, a[3:2]};
      return 32'hC000_0000 | a;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Response scoreboard.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         resp_cnt++;
         if (exp_q.size() == 0) check("resp_unexpected", 64'(resp_data), 64'hFFFF_FFFF_FFFF_FFFF);
         else check("resp_data", 64'(resp_data), 64'(exp_q.pop_front()));
      end
   end

   task automatic issue(input logic [31:0] addr, input bit expect_resp);
      check("req_ready_before_req", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      if (expect_resp) exp_q.push_back(mem_word(addr));
      tick();
      req_valid = 1'b0;
   endtask

   // Serves one refill; optional stall, flush on a beat, or reset on a beat.
   task automatic serve_line(input logic [31:0] line, input int delay,
                             input int flush_beat, input int rst_beat);
      int n = 0;
      while (mem_req_valid !== 1'b1 && n < 20) begin tick(); n++; end
      check("mem_req_valid", 64'(mem_req_valid), 64'd1);
      check("mem_req_addr", 64'(mem_req_addr), 64'(line));
      for (int i = 0; i < delay; i++) begin
         tick();
         check("stall_mem_req_valid", 64'(mem_req_valid), 64'd1);
         check("stall_mem_req_addr", 64'(mem_req_addr), 64'(line));
         check("stall_req_ready", 64'(req_ready), 64'd0);
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check("mem_req_valid_drop", 64'(mem_req_valid), 64'd0);
      for (int b = 0; b < 4; b++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem_word(line + 32'(4 * b));
         flush      = (b == flush_beat);
         if (b == rst_beat) begin
            rst_n = 1'b0;
            #1;
            check("rst_req_ready", 64'(req_ready), 64'd1);
            check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
            check("rst_resp_valid", 64'(resp_valid), 64'd0);
            tick();
            rst_n = 1'b1;
            tick();   // stray beat arrives in IDLE
            mem_rvalid = 1'b0;
            return;
         end
         tick();
         flush = 1'b0;
      end
      mem_rvalid = 1'b0;
   endtask

   initial begin
      int base;
      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
      mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      tick(); tick();
      check("reset_req_ready", 64'(req_ready), 64'd1);
      check("reset_resp_valid", 64'(resp_valid), 64'd0);
      check("reset_resp_data", 64'(resp_data), 64'd0);
      check("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check("reset_mem_req_addr", 64'(mem_req_addr), 64'd0);
      rst_n = 1'b1;
      tick();

      // Cold miss.
      issue(32'h10, 1'b1);
      check("miss_req_ready_low", 64'(req_ready), 64'd0);
      serve_line(32'h10, 0, -1, -1);
      tick();
      check("miss_resp_one_cycle", 64'(resp_valid), 64'd0);
      check("miss_idle_ready", 64'(req_ready), 64'd1);

      // Streaming hits.
      base = resp_cnt;
      req_valid = 1'b1;
      for (int i = 1; i < 4; i++) begin
         req_addr = 32'h10 + 32'(4 * i);
         exp_q.push_back(32'hA0 + 32'(i));
         check("hit_req_ready", 64'(req_ready), 64'd1);
         tick();
         check("hit_no_mem_req", 64'(mem_req_valid), 64'd0);
      end
      req_valid = 1'b0;
      tick();
      check("hit_resp_count", 64'(resp_cnt - base), 64'd3);
      check("hit_no_mem_req_end", 64'(mem_req_valid), 64'd0);

      // Conflict miss, then the evicted line misses again under backpressure.
      issue(32'h110, 1'b1);
      serve_line(32'h110, 0, -1, -1);
      tick();
      issue(32'h10, 1'b1);
      serve_line(32'h10, 5, -1, -1);
      tick();

      // Flush mid-refill: response still delivered, then one not-ready cycle.
      issue(32'h24, 1'b1);
      serve_line(32'h20, 0, 1, -1);
      tick();
      check("flush_pending_ready", 64'(req_ready), 64'd0);
      tick();
      check("flush_applied_ready", 64'(req_ready), 64'd1);
      issue(32'h24, 1'b1);
      check("flushed_line_misses", 64'(mem_req_valid), 64'd1);
      serve_line(32'h20, 0, -1, -1);
      tick();

      // Flush in IDLE together with a request to a valid line: miss.
      check("pre_flush_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_addr = 32'h28; flush = 1'b1;
      exp_q.push_back(mem_word(32'h28));
      tick();
      req_valid = 1'b0; flush = 1'b0;
      check("flush_idle_miss", 64'(mem_req_valid), 64'd1);
      serve_line(32'h20, 0, -1, -1);
      tick();

      // Reset during the second refill beat; line 0x20 is then invalid.
      issue(32'h30, 1'b0);
      serve_line(32'h30, 0, -1, 1);
      check("post_rst_idle_ready", 64'(req_ready), 64'd1);
      check("post_rst_no_resp", 64'(resp_valid), 64'd0);
      issue(32'h20, 1'b1);
      check("post_rst_miss", 64'(mem_req_valid), 64'd1);
      serve_line(32'h20, 0, -1, -1);
      tick();
      tick();
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
